// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver with an integrated first-word-fall-through receive FIFO and
// sticky line-error flags.  The serial input is brought into the CLK domain
// through a two-flop synchronizer.  A five-state FSM then samples each bit
// in the middle of its bit period.  Frames are pushed into a circular buffer
// only when the stop bit is high, the parity matches (if enabled) and there
// is room.  Otherwise the matching sticky flag is raised.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (even, >= 4)
//   DATA_BITS    : data bits per frame (5..9)
//   PARITY       : 0 none, 1 even, 2 odd
//   FIFO_DEPTH   : FIFO entries (power of two, >= 2)
//
// Ports
//   CLK          : system clock, rising edge
//   RST          : asynchronous active-high reset
//   UART_RX_i    : serial line, idle high, asynchronous to CLK
//   RD_EN_i      : pop the head entry (ignored when empty)
//   ERR_CLR_i    : clear all sticky error flags (a same-cycle set wins)
//   RD_DATA_o    : FIFO head, meaningful while RX_VALID_o = 1
//   RX_VALID_o   : FIFO not empty
//   FIFO_FULL_o  : FIFO holds FIFO_DEPTH entries
//   PARITY_ERR_o : sticky, parity mismatch seen
//   FRAME_ERR_o  : sticky, stop bit sampled low
//   OVERRUN_o    : sticky, good frame dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 32,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UART_RX_i,
    input  logic                 RD_EN_i,
    input  logic                 ERR_CLR_i,
    output logic [DATA_BITS-1:0] RD_DATA_o,
    output logic                 RX_VALID_o,
    output logic                 FIFO_FULL_o,
    output logic                 PARITY_ERR_o,
    output logic                 FRAME_ERR_o,
    output logic                 OVERRUN_o
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Expected parity bit for a data word in the configured mode.
    function automatic logic parity_expected(input logic [DATA_BITS-1:0] data);
        logic even_bit;
        even_bit = ^data;
        if (PARITY == 32'd2) begin
            return ~even_bit;
        end else begin
            return even_bit;
        end
    endfunction

    // Full when the wrap bits differ and the index bits match.
    function automatic logic ptr_full(input logic [PTR_W-1:0] wr,
                                      input logic [PTR_W-1:0] rd);
        return (wr[PTR_W-1] != rd[PTR_W-1]) &&
               (wr[ADDR_W-1:0] == rd[ADDR_W-1:0]);
    endfunction

    // Receiver state
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bad_r;
    logic                 armed_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_s;

    // FIFO state
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_nxt_s;
    logic [PTR_W-1:0]     rd_ptr_nxt_s;
    logic [DATA_BITS-1:0] rd_data_r;
    logic [DATA_BITS-1:0] rd_data_nxt_s;

    // Registered outputs
    logic                 rx_valid_r;
    logic                 fifo_full_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    // Stop-sample decode
    logic                 cnt_zero_s;
    logic                 stop_sample_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 frame_ok_s;
    logic                 no_room_s;
    logic                 push_s;
    logic                 ferr_set_s;
    logic                 perr_set_s;
    logic                 ovr_set_s;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // Receive FSM: mid-bit sampling, shift register and parity check.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= BIT_ZERO;
            shift_r   <= {DATA_BITS{1'b0}};
            par_bad_r <= 1'b0;
            armed_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // armed_r keeps a held-low line (break) from looking like
                    // a fresh start edge right after STOP.
                    if (!rx_s && armed_r) begin
                        state_r   <= ST_START;
                        cnt_r     <= HALF_LOAD;
                        bit_cnt_r <= BIT_ZERO;
                        par_bad_r <= 1'b0;
                    end else if (rx_s) begin
                        armed_r <= 1'b1;
                    end else begin
                        armed_r <= armed_r;
                    end
                end
                ST_START: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                        cnt_r   <= FULL_LOAD;
                    end
                end
                ST_DATA: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        // LSB first: new bits enter at the top and move down.
                        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                        cnt_r   <= FULL_LOAD;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= BIT_ZERO;
                            state_r   <= (PARITY != 32'd0) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        end
                    end
                end
                ST_PAR: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        par_bad_r <= (rx_s != parity_expected(shift_r));
                        cnt_r     <= FULL_LOAD;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        // Back to IDLE on the sample edge.  Only a high stop
                        // bit re-arms start detection immediately.
                        state_r <= ST_IDLE;
                        armed_r <= rx_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Stop-sample outcome and FIFO pointer arithmetic.
    always_comb begin
        cnt_zero_s    = (cnt_r == CNT_ZERO);
        stop_sample_s = (state_r == ST_STOP) && cnt_zero_s;
        fifo_full_s   = ptr_full(wr_ptr_r, rd_ptr_r);
        fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
        pop_s         = RD_EN_i && !fifo_empty_s;
        frame_ok_s    = stop_sample_s && rx_s && !par_bad_r;
        // A pop on the stop-sample cycle frees a slot in a full FIFO.
        no_room_s     = fifo_full_s && !RD_EN_i;
        ferr_set_s    = stop_sample_s && !rx_s;
        perr_set_s    = stop_sample_s && rx_s && par_bad_r;
        ovr_set_s     = frame_ok_s && no_room_s;
        push_s        = frame_ok_s && !no_room_s;
        wr_ptr_nxt_s  = wr_ptr_r + {{(PTR_W-1){1'b0}}, push_s};
        rd_ptr_nxt_s  = rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
    end

    // Next head value: the frame being pushed when it lands at the new head,
    // otherwise the stored entry; held when the FIFO will be empty.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
            if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
                rd_data_nxt_s = shift_r;
            end else begin
                rd_data_nxt_s = mem_r[rd_ptr_nxt_s[ADDR_W-1:0]];
            end
        end else begin
            rd_data_nxt_s = rd_data_r;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= shift_r;
        end
    end

    // FIFO pointers, registered status outputs and sticky error flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            rd_data_r    <= {DATA_BITS{1'b0}};
            rx_valid_r   <= 1'b0;
            fifo_full_r  <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            rd_data_r   <= rd_data_nxt_s;
            rx_valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            fifo_full_r <= ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
            // Set has priority over clear for every flag.
            if (perr_set_s) begin
                parity_err_r <= 1'b1;
            end else if (ERR_CLR_i) begin
                parity_err_r <= 1'b0;
            end else begin
                parity_err_r <= parity_err_r;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (ERR_CLR_i) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ERR_CLR_i) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign RD_DATA_o    = rd_data_r;
    assign RX_VALID_o   = rx_valid_r;
    assign FIFO_FULL_o  = fifo_full_r;
    assign PARITY_ERR_o = parity_err_r;
    assign FRAME_ERR_o  = frame_err_r;
    assign OVERRUN_o    = overrun_r;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO and sticky line-error flags. Successor to the fixed 8N1 receive path exercised by the SoC bench: bit time, data width, parity mode and buffer depth are generics, and the receiver adds glitch rejection, parity checking, framing detection and overrun reporting. Sits between the SoC `UART_RX_i` pin and the bus-side peripheral register file, which pops bytes through a first-word-fall-through read port.

## Interface
- `CLKS_PER_BIT`, 32: clock cycles per UART bit; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `FIFO_DEPTH`, 4: entries; power of two, ≥ 2.

- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `UART_RX_i` in 1: serial line, idle high, asynchronous to `CLK`.
- `RD_EN_i` in 1: pop head entry; ignored when empty.
- `ERR_CLR_i` in 1: clear all sticky error flags.
- `RD_DATA_o` out DATA_BITS: FIFO head, valid when `RX_VALID_o` = 1.
- `RX_VALID_o` out 1: FIFO not empty.
- `FIFO_FULL_o` out 1: FIFO holds FIFO_DEPTH entries.
- `PARITY_ERR_o` out 1: sticky, parity mismatch seen.
- `FRAME_ERR_o` out 1: sticky, stop bit sampled low.
- `OVERRUN_o` out 1: sticky, good frame dropped because FIFO full.

## Operation
- Reset: every output is 0, FIFO empty, FSM in IDLE, synchronizer flops preset to 1 (line idle).
- `UART_RX_i` passes through a 2-flop synchronizer; all decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: `rx_s` = 0 -> START, bit counter cleared, cycle counter loaded for a half bit.
  - START: after CLKS_PER_BIT/2 cycles, sample `rx_s`. If 1 (glitch), return to IDLE with no flag. If 0, go to DATA and reload for a full bit.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After DATA_BITS samples go to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR: sample one bit and compare it against the XOR of the data (even) or its complement (odd).
  - STOP: sample one bit, then return to IDLE on the same cycle, so the next start edge can be detected half a bit later.
- Stop-sample outcome. The first matching case wins:
  - Stop = 0: discard the frame and set FRAME_ERR.
  - Parity mismatch: discard the frame and set PARITY_ERR.
  - FIFO full with no pop this cycle: discard the frame and set OVERRUN.
  - Otherwise: push the frame into the FIFO.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers. Full when the MSBs differ and the lower bits are equal. Pointers wrap naturally.
  - `RD_DATA_o` always shows the entry at the read pointer.
  - When FIFO is empty, `RD_DATA_o` holds its last value and carries no meaning.
- Push and pop on the same cycle:
  - Both are performed and the occupancy is unchanged.
  - When full, the pop frees the slot and the push succeeds with no overrun.
  - When empty, the push lands and `RX_VALID_o` rises next cycle; the pop is ignored.
- `ERR_CLR_i` clears all three flags. If a new error is raised on the same cycle as the clear, the flag ends up set (set wins).
- A line held low (break) produces a FRAME_ERR, then FSM sits in IDLE → START → IDLE glitch loops only when the line goes high then low again. No new start is detected while `rx_s` stays 0 after STOP.

## Timing
- Let t0 be the first cycle `rx_s` = 0 in IDLE; t0 is 2–3 cycles after the `UART_RX_i` falling edge.
- Start sample at t0 + CLKS_PER_BIT/2.
- Data bit k is sampled at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample at t0 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT, where P = 1 if parity is enabled and 0 otherwise.
- The push occurs at the stop-sample edge. `RX_VALID_o`, `FIFO_FULL_o` and the error flags update on the following cycle.
- Pop: `RD_DATA_o`, `RX_VALID_o` and `FIFO_FULL_o` reflect the new head one cycle after the `RD_EN_i` edge.
- Asserting `RST` mid-frame aborts the frame immediately. No partial frame is pushed and nothing is flagged.

## Test plan
- Defaults, send 0xA5 8N1 at 32 clk/bit -> `RX_VALID_o` = 1, `RD_DATA_o` = 0xA5, no flags. Pulse `RD_EN_i` -> `RX_VALID_o` = 0.
- PARITY=1: send 0x7F with parity bit 1 -> accepted. Send 0x7F with parity bit 0 -> FIFO stays empty and `PARITY_ERR_o` = 1. Pulse `ERR_CLR_i` -> 0.
- Send 0x3C with stop bit 0 -> `FRAME_ERR_o` = 1 and nothing pushed. Then a 10-cycle low glitch -> no flag and no push.
- FIFO_DEPTH=4: send 5 frames 0x01..0x05 without reading -> `FIFO_FULL_o` = 1, `OVERRUN_o` = 1, and reads return 0x01..0x04.
- With FIFO full, assert `RD_EN_i` on the stop-sample cycle of frame 0x66 -> no overrun, occupancy stays 4, and 0x66 is the last entry read.
- Assert `RST` during data bit 4 of 0xA5 -> all outputs 0. The next full 0x5A frame is received correctly.
